// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with write-pending scoreboard.
// Holds default geometry, index/data typedefs and the popcount helper
// used to derive the busy-register count.
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    // Widest busy vector the popcount helper accepts (ADDR_W up to 8).
    localparam int MAX_REGS   = 256;

    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    function automatic int unsigned popcount(input logic [MAX_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file: writeback port, packed read
// ports with busy flags, issue handshake and the busy-register count.
// master = decode/writeback side, slave = register file.
interface regfile_sb_if #(
    parameter int DATA_W = regfile_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
    parameter int NRD    = 2
);

    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [NRD*ADDR_W-1:0]   rd_addr;
    logic [NRD*DATA_W-1:0]   rd_data;
    logic [NRD-1:0]          rd_busy;
    logic                    iss_valid;
    logic [ADDR_W-1:0]       iss_rd;
    logic                    iss_ready;
    logic [ADDR_W:0]         busy_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, iss_valid, iss_rd,
        input  rd_data, rd_busy, iss_ready, busy_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, iss_valid, iss_rd,
        output rd_data, rd_busy, iss_ready, busy_cnt
    );

endinterface

// File: rtl/regfile_word.sv
// One register-file word: a DATA_W register loaded when en is high,
// cleared by the asynchronous active-low reset.
module regfile_word
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Word storage: load on enable, clear on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register write-pending scoreboard.
// Decode reads operands and issues destinations (marking them busy);
// writeback stores data and clears busy. An issue to an already-busy
// register is refused (WAW stall). With R0_ZERO=1, R0 reads 0, is never
// busy and ignores writes/issues.
// Optional feature: define REGFILE_BYPASS_EN to forward a writeback to
// same-cycle reads and to let a same-cycle issue see the cleared busy bit.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NRD     = 2,
    parameter int R0_ZERO = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    regfile_sb_if.slave bus
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [ADDR_W:0]   busy_cnt_q;
    logic              wr_ok;
    logic              iss_r0;
    logic              wr_clr_iss;
    logic              iss_ready_c;
    logic              iss_acc;

    // Writes to a hard-wired R0 are dropped; nothing is forwarded while in reset.
    assign wr_ok  = reset_n && bus.wr_en &&
                    !((R0_ZERO != 0) && (bus.wr_addr == '0));
    assign iss_r0 = (R0_ZERO != 0) && (bus.iss_rd == '0);

`ifdef REGFILE_BYPASS_EN
    assign wr_clr_iss = wr_ok && (bus.wr_addr == bus.iss_rd);
`else
    assign wr_clr_iss = 1'b0;
`endif

    assign iss_ready_c   = iss_r0 || wr_clr_iss || !busy[bus.iss_rd];
    assign iss_acc       = bus.iss_valid && iss_ready_c && !iss_r0;
    assign bus.iss_ready = iss_ready_c;
    assign bus.busy_cnt  = busy_cnt_q;

    for (genvar i = 0; i < NREGS; i++) begin : g_word
        regfile_word #(.DATA_W(DATA_W)) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (wr_ok && (bus.wr_addr == ADDR_W'(i))),
            .d       (bus.wr_data),
            .q       (regs_q[i])
        );
    end

    // Next busy vector: writeback clears first, so an accepted issue to the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[bus.wr_addr] = 1'b0;
        end
        if (iss_acc) begin
            busy_nxt[bus.iss_rd] = 1'b1;
        end
    end

    // Scoreboard state and its population count, kept in step on every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_cnt_q <= (ADDR_W+1)'(popcount(MAX_REGS'(busy_nxt)));
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              hit_r0;
        logic              hit_wr;

        assign idx    = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign hit_r0 = (R0_ZERO != 0) && (idx == '0);
`ifdef REGFILE_BYPASS_EN
        assign hit_wr = wr_ok && (idx == bus.wr_addr);
`else
        assign hit_wr = 1'b0;
`endif
        // R0 forcing overrides the forwarded writeback.
        assign bus.rd_data[k*DATA_W +: DATA_W] = hit_r0 ? '0 :
                                                 hit_wr ? bus.wr_data : regs_q[idx];
        assign bus.rd_busy[k] = !hit_r0 && !hit_wr && busy[idx];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default instance (8x8, 2 read ports) and a
// generalised one (16-bit, 16 regs, 3 read ports, hard-wired R0). Directed
// scenarios followed by random traffic, all outputs compared each cycle
// against an array-based reference of the register/scoreboard rules.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(8),  .ADDR_W(3), .NRD(2)) ifa ();
    regfile_sb_if #(.DATA_W(16), .ADDR_W(4), .NRD(3)) ifb ();

    regfile_sb #(.DATA_W(8), .ADDR_W(3), .NRD(2), .R0_ZERO(0)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(4), .NRD(3), .R0_ZERO(1)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: index 0 = default instance, 1 = R0-zero instance.
    logic [15:0] m_regs [2][16];
    logic        m_busy [2][16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_rd(int d, int a, logic we, int wa, logic [15:0] wd);
        if (d == 1 && a == 0) return 16'h0;
        if (BYP && we && a == wa) return wd;
        return m_regs[d][a];
    endfunction

    function automatic logic m_rb(int d, int a, logic we, int wa);
        if (d == 1 && a == 0) return 1'b0;
        if (BYP && we && a == wa) return 1'b0;
        return m_busy[d][a];
    endfunction

    function automatic logic m_ready(int d, int ir, logic we, int wa);
        if (d == 1 && ir == 0) return 1'b1;
        if (BYP && we && ir == wa) return 1'b1;
        return !m_busy[d][ir];
    endfunction

    function automatic int m_count(int d);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) if (m_busy[d][i]) n++;
        return n;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) begin
                m_regs[d][i] = 16'h0;
                m_busy[d][i] = 1'b0;
            end
    endtask

    task automatic m_commit(int d, logic we, int wa, logic [15:0] wd, logic iv, int ir);
        logic rdy;
        rdy = m_ready(d, ir, we, wa);
        if (we && !(d == 1 && wa == 0)) begin
            m_regs[d][wa] = wd;
            m_busy[d][wa] = 1'b0;
        end
        if (iv && rdy && !(d == 1 && ir == 0)) m_busy[d][ir] = 1'b1;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int a;
            a = int'(ifa.rd_addr[k*3 +: 3]);
            chk("a_rd_data", 64'(ifa.rd_data[k*8 +: 8]),
                64'(m_rd(0, a, ifa.wr_en, int'(ifa.wr_addr), 16'(ifa.wr_data))));
            chk("a_rd_busy", 64'(ifa.rd_busy[k]),
                64'(m_rb(0, a, ifa.wr_en, int'(ifa.wr_addr))));
        end
        chk("a_iss_ready", 64'(ifa.iss_ready),
            64'(m_ready(0, int'(ifa.iss_rd), ifa.wr_en, int'(ifa.wr_addr))));
        chk("a_busy_cnt", 64'(ifa.busy_cnt), 64'(m_count(0)));
        for (int k = 0; k < 3; k++) begin
            int a;
            a = int'(ifb.rd_addr[k*4 +: 4]);
            chk("b_rd_data", 64'(ifb.rd_data[k*16 +: 16]),
                64'(m_rd(1, a, ifb.wr_en, int'(ifb.wr_addr), ifb.wr_data)));
            chk("b_rd_busy", 64'(ifb.rd_busy[k]),
                64'(m_rb(1, a, ifb.wr_en, int'(ifb.wr_addr))));
        end
        chk("b_iss_ready", 64'(ifb.iss_ready),
            64'(m_ready(1, int'(ifb.iss_rd), ifb.wr_en, int'(ifb.wr_addr))));
        chk("b_busy_cnt", 64'(ifb.busy_cnt), 64'(m_count(1)));
    endtask

    // Inputs are set just after a falling edge; check, then advance one cycle.
    task automatic cycle();
        #1;
        compare_all();
        m_commit(0, ifa.wr_en, int'(ifa.wr_addr), 16'(ifa.wr_data), ifa.iss_valid, int'(ifa.iss_rd));
        m_commit(1, ifb.wr_en, int'(ifb.wr_addr), ifb.wr_data, ifb.iss_valid, int'(ifb.iss_rd));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic a_set(logic we, int wa, logic [7:0] wd, logic iv, int ir, int r0, int r1);
        ifa.wr_en     = we;
        ifa.wr_addr   = 3'(wa);
        ifa.wr_data   = wd;
        ifa.iss_valid = iv;
        ifa.iss_rd    = 3'(ir);
        ifa.rd_addr   = {3'(r1), 3'(r0)};
    endtask

    task automatic b_set(logic we, int wa, logic [15:0] wd, logic iv, int ir, int r0, int r1, int r2);
        ifb.wr_en     = we;
        ifb.wr_addr   = 4'(wa);
        ifb.wr_data   = wd;
        ifb.iss_valid = iv;
        ifb.iss_rd    = 4'(ir);
        ifb.rd_addr   = {4'(r2), 4'(r1), 4'(r0)};
    endtask

    initial begin
        reset_n = 1'b0;
        a_set(1'b0, 0, 8'h00, 1'b0, 0, 0, 0);
        b_set(1'b0, 0, 16'h0, 1'b0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Build state, then pull reset mid-run with no clock edge.
        a_set(1'b1, 3, 8'h5A, 1'b0, 0, 3, 4); cycle();
        a_set(1'b0, 0, 8'h00, 1'b1, 4, 3, 4); cycle();
        a_set(1'b0, 0, 8'h00, 1'b0, 4, 3, 4);
        #1;
        chk("pre_rst_r3", 64'(ifa.rd_data[7:0]), 64'h5A);
        chk("pre_rst_busy_r4", 64'(ifa.rd_busy[1]), 64'h1);
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("rst_rd_data", 64'(ifa.rd_data), 64'h0);
        chk("rst_rd_busy", 64'(ifa.rd_busy), 64'h0);
        chk("rst_busy_cnt", 64'(ifa.busy_cnt), 64'h0);
        chk("rst_iss_ready", 64'(ifa.iss_ready), 64'h1);
        @(negedge clk);
        reset_n = 1'b1;

        // Write then read on both ports.
        a_set(1'b1, 5, 8'hA7, 1'b0, 0, 0, 0); cycle();
        a_set(1'b0, 0, 8'h00, 1'b0, 0, 5, 5);
        #1;
        chk("wr_rd_p0", 64'(ifa.rd_data[7:0]), 64'hA7);
        chk("wr_rd_p1", 64'(ifa.rd_data[15:8]), 64'hA7);
        cycle();

        // Scoreboard issue / WAW stall / clear.
        a_set(1'b0, 0, 8'h00, 1'b1, 2, 2, 2); cycle();
        a_set(1'b0, 0, 8'h00, 1'b1, 2, 2, 2);
        #1;
        chk("sb_busy", 64'(ifa.rd_busy[0]), 64'h1);
        chk("sb_cnt", 64'(ifa.busy_cnt), 64'h1);
        chk("sb_waw_ready", 64'(ifa.iss_ready), 64'h0);
        cycle();
        a_set(1'b0, 0, 8'h00, 1'b0, 2, 2, 2);
        #1;
        chk("sb_cnt_hold", 64'(ifa.busy_cnt), 64'h1);
        cycle();
        a_set(1'b1, 2, 8'h3C, 1'b0, 2, 2, 2); cycle();
        a_set(1'b0, 0, 8'h00, 1'b0, 2, 2, 2);
        #1;
        chk("sb_clr_data", 64'(ifa.rd_data[7:0]), 64'h3C);
        chk("sb_clr_busy", 64'(ifa.rd_busy[0]), 64'h0);
        chk("sb_clr_cnt", 64'(ifa.busy_cnt), 64'h0);
        cycle();

        // Write and issue the same register in one cycle.
        a_set(1'b1, 6, 8'h11, 1'b1, 6, 6, 6); cycle();
        a_set(1'b0, 0, 8'h00, 1'b0, 6, 6, 6);
        #1;
        chk("sim_data", 64'(ifa.rd_data[7:0]), 64'h11);
        chk("sim_busy", 64'(ifa.rd_busy[0]), 64'h1);
        cycle();

        // Writeback to a busy register while reading it.
        a_set(1'b0, 0, 8'h00, 1'b1, 1, 1, 1); cycle();
        a_set(1'b1, 1, 8'hFF, 1'b0, 1, 1, 1);
        #1;
        chk("byp_data", 64'(ifa.rd_data[7:0]), BYP ? 64'hFF : 64'h00);
        chk("byp_busy", 64'(ifa.rd_busy[0]), BYP ? 64'h0 : 64'h1);
        chk("byp_ready", 64'(ifa.iss_ready), BYP ? 64'h1 : 64'h0);
        cycle();
        a_set(1'b0, 0, 8'h00, 1'b0, 1, 1, 1);
        #1;
        chk("byp_next_data", 64'(ifa.rd_data[7:0]), 64'hFF);
        chk("byp_next_busy", 64'(ifa.rd_busy[0]), 64'h0);
        cycle();

        // Generalised instance: hard-wired R0 and a 3-port read of R15.
        b_set(1'b1, 0, 16'h1234, 1'b0, 0, 0, 0, 0); cycle();
        b_set(1'b0, 0, 16'h0, 1'b1, 0, 0, 0, 0);
        #1;
        chk("b_r0_ready", 64'(ifb.iss_ready), 64'h1);
        cycle();
        b_set(1'b0, 0, 16'h0, 1'b0, 0, 0, 0, 0);
        #1;
        chk("b_r0_data", 64'(ifb.rd_data), 64'h0);
        chk("b_r0_busy", 64'(ifb.rd_busy), 64'h0);
        chk("b_r0_cnt", 64'(ifb.busy_cnt), 64'h0);
        cycle();
        b_set(1'b1, 15, 16'hBEEF, 1'b0, 0, 15, 15, 15); cycle();
        b_set(1'b0, 0, 16'h0, 1'b0, 0, 15, 15, 15);
        #1;
        chk("b_r15_all", 64'(ifb.rd_data), 64'h0000_BEEF_BEEF_BEEF);
        cycle();

        // Random traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            a_set(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            b_set(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with an integrated write-pending scoreboard. It is the next generation of the 8×8 CPU register file. Register width, register count, read-port count and hard-wired-zero R0 are configurable. It adds asynchronous reset and per-register busy tracking, so the decode stage can detect RAW and WAW hazards against multi-cycle writebacks. It sits between decode (read and issue) and writeback (write and clear).

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, register index width; NREGS = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- R0_ZERO, 0, when 1: R0 always reads 0, is never busy, and ignores writes

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset_n  input  1  asynchronous, active-low reset
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback destination
- wr_data  input  DATA_W  writeback data
- rd_addr  input  NRD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NRD*DATA_W  packed read data, combinational
- rd_busy  output  NRD  per-port flag: the addressed register has a pending write
- iss_valid  input  1  decode requests to mark iss_rd pending
- iss_rd  input  ADDR_W  destination being issued
- iss_ready  output  1  combinational; 0 when iss_rd is already busy (WAW stall)
- busy_cnt  output  ADDR_W+1  number of registers currently busy

## Operation
- State: regs[NREGS] of DATA_W bits; busy[NREGS] of 1 bit.
- Write: on a clk rise with wr_en=1, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0. A write to a non-busy register is legal and leaves it non-busy.
- Issue: an issue is accepted when iss_valid=1 and iss_ready=1. On the next clk rise, busy[iss_rd] <= 1. When iss_valid=1 and iss_ready=0, nothing changes.
- iss_ready = ~busy[iss_rd], with the modifications below.
- Same register written and issued in one cycle: the issue wins and busy ends at 1. The data is still written.
- With R0_ZERO=1:
  - Writes and issues to R0 are ignored.
  - iss_ready is 1 for R0.
  - rd_data for R0 is 0 and rd_busy for R0 is 0.
- Reads: rd_data[k] = regs[rd_addr[k]] and rd_busy[k] = busy[rd_addr[k]], both combinational.
- busy_cnt equals the population count of busy, registered so that it matches busy after each edge.
- Out-of-range values cannot occur, because NREGS = 2**ADDR_W.

## Timing
- Reset, asynchronous on reset_n low:
  - every regs entry is 0 and every busy bit is 0
  - busy_cnt is 0
  - iss_ready is 1
  - rd_data is all 0 and rd_busy is all 0
- Deassertion of reset_n takes effect at the next clk rise.
- A reset asserted mid-operation discards all pending state immediately.
- Write latency: a write is visible on rd_data one cycle after its edge. With REGFILE_BYPASS_EN it is visible in the same cycle.
- Issue latency: busy is visible on rd_busy and iss_ready on the cycle after acceptance.
- Clear latency: busy clears on the edge that performs the write.

## Configuration
- REGFILE_BYPASS_EN defined: when wr_en=1 and rd_addr[k]==wr_addr, the write is forwarded in the same cycle:
  - rd_data[k] = wr_data and rd_busy[k] = 0
  - iss_ready uses the post-clear busy value, so an issue to wr_addr in the writeback cycle is accepted
- The R0_ZERO rules take precedence over the bypass.
- REGFILE_BYPASS_EN undefined: reads and iss_ready reflect stored state only, and the writeback cycle still shows the old data and busy=1.

## Structure
- The shared package regfile_pkg holds:
  - the default DATA_W/ADDR_W constants
  - typedef reg_idx_t (ADDR_W bits) and data_t (DATA_W bits)
  - a popcount function used by busy_cnt
- Sub-module regfile_word: one DATA_W register with clk, reset_n, enable and d/q. regfile_sb instantiates NREGS of these. The busy vector stays in the top level.

## Test plan
- Reset with default parameters: assert reset_n=0 mid-run after writing R3=0x5A and issuing R4 -> all rd_data=0x00, rd_busy=0, busy_cnt=0, iss_ready=1, with no clock edge required.
- Write and read: write R5=0xA7, then read ports 0 and 1 both at R5 -> 0xA7 on both, one cycle after the write edge.
- Scoreboard: issue R2, then read R2 -> rd_busy=1 and busy_cnt=1. A second issue to R2 gives iss_ready=0 and busy_cnt stays 1. Write R2=0x3C -> busy clears and busy_cnt=0.
- Simultaneous events: write R6=0x11 and issue R6 in the same cycle -> R6 reads 0x11 and busy[6]=1.
- Bypass, run both builds:
  - R1 busy, then wr_en with R1=0xFF while port 0 reads R1.
  - With REGFILE_BYPASS_EN: same cycle shows 0xFF, busy=0, and iss_ready=1 for R1.
  - Without it: old value and busy=1 that cycle; 0xFF and busy=0 on the next cycle.
- Generalisation: DATA_W=16, ADDR_W=4, NRD=3, R0_ZERO=1. Write R0=0x1234 and issue R0 -> R0 reads 0x0000 and is never busy. Write R15=0xBEEF -> all three ports read 0xBEEF at R15.
